tuple_yielder: RTL and testbench

TUPLE_YIELDER -- requirements
Module: tuple_yielder

---
 rtl/tuple_yielder.sv | 116 +++++++++++
 tb/tb_tuple_yielder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tuple_yielder.sv
// Yields up to N_YIELDS latched tuples one per accepted handshake, then flags done.
// Start-to-valid latency one cycle; _out/_valid hold for any stall while _ready is low.
module tuple_yielder #(
  parameter int WIDTH    = 32,
  parameter int N_OUT    = 2,
  parameter int N_YIELDS = 4
) (
  input  logic                               _clock,
  input  logic                               _reset,
  input  logic                               _start,
  input  logic [$clog2(N_YIELDS+1)-1:0]      _len,
  input  logic [N_YIELDS*N_OUT*WIDTH-1:0]    _in,
  input  logic                               _ready,
  output logic [N_OUT*WIDTH-1:0]             _out,
  output logic                               _valid,
  output logic                               _done
);

  localparam int LW = $clog2(N_YIELDS + 1);
  localparam int IW = (N_YIELDS > 1) ? $clog2(N_YIELDS) : 1;
  localparam int TW = N_OUT * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [LW-1:0]                  len_q, len_d;
  logic [N_YIELDS-1:0][TW-1:0]    buf_q, buf_d;
  logic [TW-1:0]                  out_q, out_d;
  logic                           valid_q, valid_d;
  logic                           done_q, done_d;

  logic [LW-1:0]                  len_clamp;
  logic [IW-1:0]                  idx_next;
  logic                           is_last;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    buf_d     = buf_q;
    out_d     = out_q;
    valid_d   = valid_q;
    done_d    = done_q;
    len_clamp = (_len > LW'(N_YIELDS)) ? LW'(N_YIELDS) : _len;
    idx_next  = idx_q + IW'(1);
    is_last   = ((LW'(idx_q) + LW'(1)) == len_q);

    case (state_q)
      IDLE, DONE: begin
        if (_start) begin
          buf_d = _in;
          len_d = len_clamp;
          idx_d = '0;
          if (len_clamp == '0) begin
            // Empty run: straight to DONE, never raising valid.
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = EMIT;
            valid_d = 1'b1;
            done_d  = 1'b0;
            out_d   = _in[TW-1:0];
          end
        end
      end
      EMIT: begin
        if (_ready) begin
          if (is_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_next;
            out_d = buf_q[idx_next];
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign _out   = out_q;
  assign _valid = valid_q;
  assign _done  = done_q;

endmodule

// File: tb/tb_tuple_yielder.sv
// Directed bench for tuple_yielder: queue-based reference model checked every negedge,
// plus hand-computed literal expectations per scenario.
module tb_tuple_yielder;
  localparam int W  = 32;
  localparam int NO = 2;
  localparam int NY = 4;
  localparam int LW = 3;
  localparam int TW = NO * W;

  logic            _clock = 1'b0;
  logic            _reset;
  logic            _start;
  logic            _ready;
  logic [LW-1:0]   _len;
  logic [NY*TW-1:0] _in;
  logic [TW-1:0]   _out;
  logic            _valid;
  logic            _done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  tuple_yielder #(.WIDTH(W), .N_OUT(NO), .N_YIELDS(NY)) dut (
    ._clock(_clock),
    ._reset(_reset),
    ._start(_start),
    ._len  (_len),
    ._in   (_in),
    ._ready(_ready),
    ._out  (_out),
    ._valid(_valid),
    ._done (_done)
  );

  always #5 _clock = ~_clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] tup(input int a, input int b);
    return {b[31:0], a[31:0]};
  endfunction

  function automatic logic [NY*TW-1:0] seq_in();
    logic [NY*TW-1:0] r;
    r = '0;
    for (int k = 0; k < NY * NO; k++) r[k*W +: W] = 32'(k + 1);
    return r;
  endfunction

  // Reference model: the run is a queue of pending tuples; head is what _out must show.
  logic [TW-1:0] mq[$];
  logic [TW-1:0] m_out   = '0;
  logic          m_valid = 1'b0;
  logic          m_done  = 1'b0;
  logic [TW-1:0] xfer_log[$];

  initial forever begin
    int n;
    @(posedge _clock or posedge _reset);
    if (_reset) begin
      mq.delete();
      m_out = '0; m_valid = 1'b0; m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (_ready) begin
        mq.delete(0);
        if (mq.size() == 0) begin
          m_valid = 1'b0; m_done = 1'b1;
        end else begin
          m_out = mq[0];
        end
      end
    end else if (_start) begin
      n = (int'(_len) > NY) ? NY : int'(_len);
      for (int t = 0; t < n; t++) mq.push_back(_in[t*TW +: TW]);
      m_done = (n == 0);
      if (n != 0) begin
        m_valid = 1'b1;
        m_out   = mq[0];
      end
    end
  end

  // Inputs only change just after posedge, so at negedge valid&&ready predicts the next transfer.
  initial forever begin
    @(negedge _clock);
    if (cmp_en) begin
      chk("model_valid", 64'(_valid), 64'(m_valid));
      chk("model_done",  64'(_done),  64'(m_done));
      chk("model_out",   64'(_out),   64'(m_out));
      if (_valid && _ready) xfer_log.push_back(_out);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge _clock);
    #1;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!_done && k < 50) begin
      step(1);
      k++;
    end
    chk(name, 64'(_done), 64'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    _reset = 1'b0; _start = 1'b0; _ready = 1'b0; _len = '0; _in = '0;
    #1 _reset = 1'b1;
    #20 _reset = 1'b0;
    cmp_en = 1'b1;
    step(2);
    chk("rst_valid", 64'(_valid), 64'd0);
    chk("rst_done",  64'(_done),  64'd0);
    chk("rst_out",   64'(_out),   64'd0);

    // Basic two-tuple run with ready held high.
    _in = seq_in(); _len = 3'd2; _ready = 1'b1; _start = 1'b1;
    step(1); _start = 1'b0;
    chk("s1_c1_valid", 64'(_valid), 64'd1);
    chk("s1_c1_out",   64'(_out),   64'(tup(1, 2)));
    step(1);
    chk("s1_c2_out",   64'(_out),   64'(tup(3, 4)));
    step(1);
    chk("s1_c3_done",  64'(_done),  64'd1);
    chk("s1_c3_valid", 64'(_valid), 64'd0);

    // Restart from DONE with a stalling consumer.
    xfer_log.delete();
    _len = 3'd4; _ready = 1'b0; _start = 1'b1;
    step(1); _start = 1'b0;
    chk("s2_done_fell", 64'(_done), 64'd0);
    chk("s2_first",     64'(_out),  64'(tup(1, 2)));
    begin
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        _ready = pat[i][0];
        step(1);
      end
    end
    _ready = 1'b0;
    chk("s2_done", 64'(_done), 64'd1);
    chk("s2_nxfer", 64'(xfer_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++)
      chk($sformatf("s2_xfer%0d", i), 64'(xfer_log[i]), 64'(tup(2 * i + 1, 2 * i + 2)));

    // Zero length, then an over-long length that clamps.
    _len = 3'd0; _ready = 1'b1; _start = 1'b1;
    step(1); _start = 1'b0;
    chk("s3_zero_done",  64'(_done),  64'd1);
    chk("s3_zero_valid", 64'(_valid), 64'd0);
    step(3);
    xfer_log.delete();
    _len = 3'd7; _start = 1'b1;
    step(1); _start = 1'b0;
    wait_done("s3_clamp_done");
    chk("s3_clamp_nxfer", 64'(xfer_log.size()), 64'd4);
    if (xfer_log.size() == 4) chk("s3_last", 64'(xfer_log[3]), 64'(tup(7, 8)));

    // Inputs and start disturbed mid-run must not affect it.
    xfer_log.delete();
    _len = 3'd3; _ready = 1'b0; _start = 1'b1;
    step(1);
    _in = '1; _len = 3'd1;
    step(2);
    _start = 1'b0; _ready = 1'b1;
    wait_done("s4_done");
    chk("s4_nxfer", 64'(xfer_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < xfer_log.size(); i++)
      chk($sformatf("s4_xfer%0d", i), 64'(xfer_log[i]), 64'(tup(2 * i + 1, 2 * i + 2)));
    _ready = 1'b0; _start = 1'b1;
    step(1); _start = 1'b0;
    chk("s4_neg_out",   64'(_out),   64'(tup(-1, -1)));
    chk("s4_neg_valid", 64'(_valid), 64'd1);
    _ready = 1'b1;
    step(1);
    chk("s4_neg_done", 64'(_done), 64'd1);

    // Asynchronous reset in the middle of a run.
    _in = seq_in(); _len = 3'd4; _ready = 1'b1; _start = 1'b1;
    step(1); _start = 1'b0;
    step(1);
    chk("s5_pre_out", 64'(_out), 64'(tup(3, 4)));
    #2 _reset = 1'b1; _ready = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(_valid), 64'd0);
    chk("s5_rst_done",  64'(_done),  64'd0);
    chk("s5_rst_out",   64'(_out),   64'd0);
    @(negedge _clock);
    #2 _reset = 1'b0;
    _ready = 1'b1;
    step(2);
    chk("s5_idle_valid", 64'(_valid), 64'd0);
    xfer_log.delete();
    _len = 3'd2; _start = 1'b1;
    step(1); _start = 1'b0;
    wait_done("s5_after_done");
    chk("s5_nxfer", 64'(xfer_log.size()), 64'd2);
    if (xfer_log.size() == 2) chk("s5_first", 64'(xfer_log[0]), 64'(tup(1, 2)));

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
